trig_scheduler: RTL and testbench
=================================

TRIG_SCHEDULER -- requirements
Module: trig_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command queue depth (power of two, >= 2).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of num/step/wait fields and counters.
REQ-003 SHALL have port I_clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port I_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port I_cmd_valid, input, 1, meaning command offered (from ISA decode TRIG write).
REQ-006 SHALL have port I_cmd_num, input, CNT_W, meaning pulse count.
REQ-007 SHALL have port I_cmd_step, input, CNT_W, meaning cycles between pulses.
REQ-008 SHALL have port I_cmd_wait, input, CNT_W, meaning cycles of delay before first pulse.
REQ-009 SHALL have port O_cmd_ready, output, 1, meaning queue can accept; push = I_cmd_valid & O_cmd_ready.
REQ-010 SHALL have port I_abort, input, 1, meaning flush queue and stop current command.
REQ-011 SHALL have port O_trig, output, 1, meaning one-cycle trigger pulse.
REQ-012 SHALL have port O_pulse_idx, output, CNT_W, meaning 0-based index of the pulse on O_trig.
REQ-013 SHALL have port O_done, output, 1, meaning one-cycle completion strobe per executed command.
REQ-014 SHALL have port O_busy, output, 1, meaning state != IDLE or queue non-empty.
REQ-015 SHALL have port O_level, output, clog2(FIFO_DEPTH)+1, meaning queue occupancy.

Function
REQ-016 SHALL hold commands in a FIFO of FIFO_DEPTH entries {num, step, wait}; O_cmd_ready = !full & !I_abort.
REQ-017 SHALL implement FSM states IDLE, WAIT, PULSE, GAP.
REQ-018 SHALL pop in IDLE when queue non-empty (cycle T); next state WAIT if wait>0, else PULSE; if num==0, next state IDLE with O_done=1 at T+1 and no pulses.
REQ-019 SHALL in WAIT load counter with wait at entry, decrement per cycle, enter PULSE so the first pulse occurs at cycle T+1+wait.
REQ-020 SHALL in PULSE assert O_trig for exactly one cycle with O_pulse_idx = k; pulse k occurs at T+1+wait+k*S, where S = max(step,1).
REQ-021 SHALL in GAP count S-1 cycles and then return to PULSE; step of 0 or 1 yields pulses on consecutive cycles with no GAP cycles.
REQ-022 SHALL assert O_done in the same cycle as the last pulse (k = num-1), then go to IDLE; the next pop occurs no earlier than the following cycle.
REQ-023 SHALL accept a push while executing or in the same cycle as a pop; occupancy is unchanged when both occur.
REQ-024 SHALL ignore I_cmd_valid when O_cmd_ready=0; no command is lost or duplicated.
REQ-025 SHALL, on I_abort, empty the FIFO, force IDLE on the next cycle, deassert O_trig and O_done in that cycle, and drop any push offered in that cycle.
REQ-026 SHALL use full CNT_W unsigned arithmetic; wait and step of 2^CNT_W-1 are honoured without wrap; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, on I_rst high at a clock edge, set state IDLE, FIFO empty, all counters 0, O_trig=0, O_pulse_idx=0, O_done=0, O_busy=0, O_level=0; O_cmd_ready SHALL be 1 from the first cycle after reset release.
REQ-028 SHALL give I_rst priority over I_abort and I_cmd_valid; reset mid-command discards it without a pulse or done.

Structure
REQ-029 SHALL place the state enumeration and the command-record field widths/offsets in a shared package trig_pkg.
REQ-030 SHALL instantiate one sub-module, trig_cmd_fifo (synchronous FIFO, show-ahead read), for command storage; FSM and counters in trig_scheduler.

Verification
REQ-031 SHALL verify: push {num=3, step=4, wait=5} at idle, pop at T -> O_trig at T+6, T+10, T+14, idx 0,1,2; O_done at T+14.
REQ-032 SHALL verify: push {num=4, step=0, wait=0} -> four consecutive O_trig cycles starting at T+1, O_done with idx 3.
REQ-033 SHALL verify: push {num=0, step=7, wait=9} -> no O_trig, single O_done at T+1, then IDLE.
REQ-034 SHALL verify: five pushes back-to-back with FIFO_DEPTH=4 while busy -> O_cmd_ready low at level 4, fifth held until a pop, all five executed in order.
REQ-035 SHALL verify: I_abort during GAP of {num=5, step=10, wait=0} with 2 queued -> no further O_trig/O_done, O_level=0, IDLE next cycle.
REQ-036 SHALL verify: I_rst asserted during WAIT -> all outputs at reset values next cycle, no pulse emitted afterward.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared definitions for the trigger scheduler: FSM states and the command-record layout.
package trig_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StPulse,
    StGap
  } trig_state_e;

  // Every field is CNT_W bits wide; offsets are expressed in units of CNT_W.
  localparam int unsigned NumFields = 3;
  localparam int unsigned NumOff    = 0;
  localparam int unsigned StepOff   = 1;
  localparam int unsigned WaitOff   = 2;

  function automatic int unsigned rec_width(input int unsigned cnt_w);
    return NumFields * cnt_w;
  endfunction

endpackage

// File: rtl/trig_cmd_fifo.sv
// Synchronous show-ahead FIFO holding trigger command records.
module trig_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne   = (AddrW + 1)'(1);
  localparam logic [AddrW:0] LevelMax = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem [Depth];
  // One extra pointer bit separates full from empty; pointers wrap modulo 2*Depth.
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == LevelMax);
  assign rdata   = mem[rd_ptr_q[AddrW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AddrW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

endmodule

// File: rtl/trig_scheduler.sv
// Queued trigger generator: each command emits num pulses after a wait, spaced by step cycles.
module trig_scheduler
  import trig_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic                        I_cmd_valid,
  input  logic [CNT_W-1:0]            I_cmd_num,
  input  logic [CNT_W-1:0]            I_cmd_step,
  input  logic [CNT_W-1:0]            I_cmd_wait,
  output logic                        O_cmd_ready,
  input  logic                        I_abort,
  output logic                        O_trig,
  output logic [CNT_W-1:0]            O_pulse_idx,
  output logic                        O_done,
  output logic                        O_busy,
  output logic [$clog2(FIFO_DEPTH):0] O_level
);

  localparam int unsigned RecW = rec_width(CNT_W);
  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  trig_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             zero_done_q, zero_done_d;

  logic [RecW-1:0]  cmd_wdata, head;
  logic [CNT_W-1:0] head_num, head_step, head_wait;
  logic             fifo_full, fifo_empty, push, pop, trig, done;

  always_comb begin
    cmd_wdata = '0;
    cmd_wdata[NumOff*CNT_W  +: CNT_W] = I_cmd_num;
    cmd_wdata[StepOff*CNT_W +: CNT_W] = I_cmd_step;
    cmd_wdata[WaitOff*CNT_W +: CNT_W] = I_cmd_wait;
  end

  assign head_num  = head[NumOff*CNT_W  +: CNT_W];
  assign head_step = head[StepOff*CNT_W +: CNT_W];
  assign head_wait = head[WaitOff*CNT_W +: CNT_W];

  assign O_cmd_ready = !fifo_full && !I_abort;
  assign push        = I_cmd_valid && O_cmd_ready;

  trig_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (RecW)
  ) u_fifo (
    .clk   (I_clk),
    .rst   (I_rst),
    .flush (I_abort),
    .push  (push),
    .wdata (cmd_wdata),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (O_level)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    num_d       = num_q;
    step_d      = step_q;
    zero_done_d = 1'b0;
    pop         = 1'b0;
    trig        = 1'b0;
    done        = 1'b0;

    if (I_rst || I_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          // The cycle carrying a zero-pulse done strobe is not allowed to pop.
          if (!fifo_empty && !zero_done_q) begin
            pop    = 1'b1;
            num_d  = head_num;
            step_d = head_step;
            idx_d  = '0;
            cnt_d  = head_wait;
            if (head_num == '0) begin
              zero_done_d = 1'b1;
            end else if (head_wait != '0) begin
              state_d = StWait;
            end else begin
              state_d = StPulse;
            end
          end
        end
        StWait: begin
          if (cnt_q == One) state_d = StPulse;
          else              cnt_d   = cnt_q - One;
        end
        StPulse: begin
          trig = 1'b1;
          if (idx_q == num_q - One) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + One;
            if (step_q > One) begin
              cnt_d   = step_q - One;
              state_d = StGap;
            end
          end
        end
        StGap: begin
          if (cnt_q == One) state_d = StPulse;
          else              cnt_d   = cnt_q - One;
        end
      endcase
      if (zero_done_q) done = 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      step_q      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      step_q      <= step_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign O_trig      = trig;
  assign O_pulse_idx = trig ? idx_q : '0;
  assign O_done      = done;
  assign O_busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_trig_scheduler.sv
// Scoreboard bench: a timeline model predicts every pulse/done; a monitor matches DUT strobes.
module tb_trig_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  cmd_num = '0, cmd_step = '0, cmd_wait = '0;
  logic          cmd_ready, trig, done, busy;
  logic [W-1:0]  pulse_idx;
  logic [LW-1:0] level;

  trig_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (W)
  ) dut (
    .I_clk       (clk),
    .I_rst       (rst),
    .I_cmd_valid (cmd_valid),
    .I_cmd_num   (cmd_num),
    .I_cmd_step  (cmd_step),
    .I_cmd_wait  (cmd_wait),
    .O_cmd_ready (cmd_ready),
    .I_abort     (abort),
    .O_trig      (trig),
    .O_pulse_idx (pulse_idx),
    .O_done      (done),
    .O_busy      (busy),
    .O_level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {int num; int step; int wt;} cmd_t;
  typedef struct {int cyc; int idx; bit is_trig; bit is_done;} evt_t;

  cmd_t mq[$];
  evt_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   gate = 0;
  int   act_lo = 1;
  int   act_hi = 0;
  int   arm_cyc = 0;
  bit   armed = 1'b0;
  bit   saw_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  // Pulse k of a command popped at t0 lands at t0+1+wait+k*max(step,1).
  task automatic schedule(input cmd_t c, input int t0);
    int s;
    int t;
    t = t0;
    if (c.num == 0) begin
      exp_q.push_back('{t0 + 1, 0, 1'b0, 1'b1});
      gate   = t0 + 2;
      act_lo = 1;
      act_hi = 0;
    end else begin
      s = (c.step == 0) ? 1 : c.step;
      for (int k = 0; k < c.num; k++) begin
        t = t0 + 1 + c.wt + k * s;
        exp_q.push_back('{t, k, 1'b1, (k == c.num - 1)});
      end
      act_lo = t0 + 1;
      act_hi = t;
      gate   = t + 1;
    end
  endtask

  // Reference model: one step per cycle, using that cycle's inputs.
  always @(negedge clk) begin
    bit   ready_m;
    bit   busy_m;
    cmd_t c;
    ready_m = (mq.size() < DEPTH) && !abort;
    busy_m  = (cyc >= act_lo && cyc <= act_hi) || (mq.size() != 0);
    if (armed) begin
      chk("level", int'(level), mq.size());
      chk("cmd_ready", int'(cmd_ready), int'(ready_m));
      chk("busy", int'(busy), int'(busy_m));
    end
    if (rst) begin
      mq.delete();
      exp_q.delete();
      act_lo = 1;
      act_hi = 0;
      gate   = cyc + 1;
      if (!armed) begin
        armed   = 1'b1;
        arm_cyc = cyc;
      end
    end else if (abort) begin
      mq.delete();
      exp_q.delete();
      if (act_hi > cyc) act_hi = cyc;
      gate = cyc + 1;
    end else begin
      if (cmd_valid && !ready_m) saw_full = 1'b1;
      if (mq.size() != 0 && cyc >= gate) begin
        c = mq.pop_front();
        schedule(c, cyc);
      end
      if (cmd_valid && ready_m) mq.push_back('{int'(cmd_num), int'(cmd_step), int'(cmd_wait)});
    end
  end

  // Monitor: consumes expected strobes whenever the DUT shows one.
  always @(negedge clk) begin
    evt_t e;
    #1;
    if (armed && cyc > arm_cyc) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event cycle %0d: got nothing expected trig=%0d done=%0d idx=%0d at %0d",
                 cyc, e.is_trig, e.is_done, e.idx, e.cyc);
      end
      if (trig || done) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output cycle %0d: got trig=%0d done=%0d idx=%0d expected none",
                   cyc, trig, done, pulse_idx);
        end else begin
          e = exp_q.pop_front();
          chk("trig", int'(trig), int'(e.is_trig));
          chk("done", int'(done), int'(e.is_done));
          if (e.is_trig) chk("pulse_idx", int'(pulse_idx), e.idx);
        end
      end
    end
  end

  // Called aligned to posedge+1; returns aligned to posedge+1 after acceptance.
  task automatic push_cmd(input int n, input int s, input int w);
    bit ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_num   = W'(n);
    cmd_step  = W'(s);
    cmd_wait  = W'(w);
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = cmd_ready;
      if (!ok) @(posedge clk);
    end
    chk("push_accepted", int'(ok), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      #2;
      ok = !busy && (exp_q.size() == 0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle_timeout: got busy=%0d pending=%0d expected idle", name, busy, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    chk({name, "_level"}, int'(level), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_trig"}, int'(trig), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_idx"}, int'(pulse_idx), 0);
    chk({name, "_ready"}, int'(cmd_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("reset");

    push_cmd(3, 4, 5);
    wait_idle("basic");
    push_cmd(4, 0, 0);
    wait_idle("back_to_back_pulses");
    push_cmd(0, 7, 9);
    wait_idle("zero_num");

    saw_full = 1'b0;
    push_cmd(3, 6, 4);
    push_cmd(1, 0, 0);
    push_cmd(2, 2, 1);
    push_cmd(0, 3, 3);
    push_cmd(3, 1, 0);
    push_cmd(2, 4, 2);
    chk("fifo_filled", int'(saw_full), 1);
    wait_idle("fill");

    push_cmd(5, 10, 0);
    push_cmd(2, 1, 1);
    push_cmd(3, 2, 0);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_level", int'(level), 0);
    chk("abort_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    #1;
    wait_idle("abort");

    push_cmd(2, 3, 20);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("mid_reset");
    repeat (40) @(posedge clk);
    #1;
    wait_idle("mid_reset");

    push_cmd(2, 255, 255);
    push_cmd(1, 0, 255);
    wait_idle("max_values");

    for (int i = 0; i < 1500; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_num   = W'($urandom_range(0, 4));
      cmd_step  = W'($urandom_range(0, 5));
      cmd_wait  = W'($urandom_range(0, 6));
      abort     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 249) == 0);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    rst       = 1'b0;
    wait_idle("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: got no finish expected finish before cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
